// File: rtl/neptuno_spi_pkg.sv
// Shared types for the SPI source arbiter: FSM state encoding and owner-index width.
package neptuno_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Owner index width; a two-source arbiter still needs one bit.
  function automatic int ow_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser with a selectable reset level.
module sync_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {SYNC_STAGES{RESET_VAL}};
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_src_arbiter.sv
// Arbitrates several asynchronous SPI masters onto one guest-core SPI bus,
// granting on synchronised slave-select and enforcing an idle guard gap after release.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no owner; grant lowest synchronised low select
// ST_OWN     | bus routed to owner; watch for owner release and conflicts
// ST_RELEASE | guard gap; count down GUARD_CYCLES, no grants
module spi_src_arbiter
  import neptuno_spi_pkg::*;
#(
  parameter int   NSRC         = 3,
  parameter int   SYNC_STAGES  = 2,
  parameter int   GUARD_CYCLES = 4,
  parameter logic SCK_IDLE     = 1'b0
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic [NSRC-1:0]             src_sck,
  input  logic [NSRC-1:0]             src_ss_n,
  input  logic [NSRC-1:0]             src_mosi,
  input  logic                        miso_in,
  output logic [NSRC-1:0]             src_miso,
  output logic                        out_sck,
  output logic                        out_mosi,
  output logic                        out_ss_n,
  output logic [ow_width(NSRC)-1:0]   owner,
  output logic                        owner_valid,
  output logic                        conflict,
  output logic [7:0]                  conflict_cnt
);

  localparam int OW = ow_width(NSRC);

  arb_state_t      state;
  logic [7:0]      guard_cnt;
  logic [NSRC-1:0] ss_sync;
  logic [NSRC-1:0] ss_prev;
  logic [NSRC-1:0] ss_fall;
  logic [NSRC-1:0] owner_sel;
  logic [OW-1:0]   grant_idx;
  logic            any_req;
  logic            owner_ss_n;
  logic            conflict_hit;
  logic            routed;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_sync
    sync_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_VAL  (1'b1)
    ) u_sync (
      .clk(CLOCK_50),
      .rst(RESET),
      .d  (src_ss_n[gi]),
      .q  (ss_sync[gi])
    );
  end

  // Scan from the top so the lowest requesting index is the one left standing.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (!ss_sync[i]) begin
        any_req   = 1'b1;
        grant_idx = OW'(i);
      end
    end
  end

  always_comb begin
    owner_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      owner_sel[i] = (owner == OW'(i));
    end
  end

  assign owner_ss_n   = |(ss_sync & owner_sel);
  assign ss_fall      = ss_prev & ~ss_sync;
  assign conflict_hit = (state == ST_OWN) && (|(ss_fall & ~owner_sel));

  // RESET gates routing directly so the bus idles before any clock edge.
  assign routed   = (state == ST_OWN) && owner_valid && !RESET;
  assign out_ss_n = routed ? |(src_ss_n & owner_sel) : 1'b1;
  assign out_sck  = routed ? |(src_sck  & owner_sel) : SCK_IDLE;
  assign out_mosi = routed ? |(src_mosi & owner_sel) : 1'b0;
  assign src_miso = routed ? (owner_sel & {NSRC{miso_in}}) : '0;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      owner        <= '0;
      owner_valid  <= 1'b0;
      guard_cnt    <= 8'd0;
      ss_prev      <= '1;
      conflict     <= 1'b0;
      conflict_cnt <= 8'd0;
    end else begin
      ss_prev  <= ss_sync;
      conflict <= conflict_hit;
      if (conflict_hit && (conflict_cnt != 8'hFF)) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner       <= grant_idx;
            owner_valid <= 1'b1;
            state       <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (owner_ss_n) begin
            owner_valid <= 1'b0;
            guard_cnt   <= 8'(GUARD_CYCLES);
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (guard_cnt <= 8'd1) begin
            guard_cnt <= 8'd0;
            state     <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 8'd1;
          end
        end
        default: begin
          owner_valid <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_src_arbiter.sv
// Directed bench for spi_src_arbiter: default 3-source instance plus an 8-source, 1-cycle-guard instance.
module tb_spi_src_arbiter;

  localparam int GUARD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] a_sck, a_ss_n, a_mosi, a_src_miso;
  logic       a_miso, a_out_sck, a_out_mosi, a_out_ss_n, a_ov, a_conf;
  logic [1:0] a_owner;
  logic [7:0] a_cnt;

  logic [7:0] b_sck, b_ss_n, b_mosi, b_src_miso;
  logic       b_miso, b_out_sck, b_out_mosi, b_out_ss_n, b_ov, b_conf;
  logic [2:0] b_owner;
  logic [7:0] b_cnt;

  spi_src_arbiter u_a (
    .CLOCK_50(clk), .RESET(rst),
    .src_sck(a_sck), .src_ss_n(a_ss_n), .src_mosi(a_mosi), .miso_in(a_miso),
    .src_miso(a_src_miso), .out_sck(a_out_sck), .out_mosi(a_out_mosi), .out_ss_n(a_out_ss_n),
    .owner(a_owner), .owner_valid(a_ov), .conflict(a_conf), .conflict_cnt(a_cnt)
  );

  spi_src_arbiter #(.NSRC(8), .GUARD_CYCLES(1)) u_b (
    .CLOCK_50(clk), .RESET(rst),
    .src_sck(b_sck), .src_ss_n(b_ss_n), .src_mosi(b_mosi), .miso_in(b_miso),
    .src_miso(b_src_miso), .out_sck(b_out_sck), .out_mosi(b_out_mosi), .out_ss_n(b_out_ss_n),
    .owner(b_owner), .owner_valid(b_ov), .conflict(b_conf), .conflict_cnt(b_cnt)
  );

  typedef struct {
    logic [2:0] ss_n;
    logic [1:0] exp_owner;
  } prio_vec_t;

  // exp = {out_sck, out_mosi, src_miso[2:0]} with source 1 owning the bus
  typedef struct {
    logic [2:0] sck;
    logic [2:0] mosi;
    logic       miso;
    logic [4:0] exp;
  } route_vec_t;

  prio_vec_t  prio_tbl [6];
  route_vec_t route_tbl[4];

  int n_tests = 0;
  int n_fail  = 0;

  int   conf_total  = 0;
  int   conf_double = 0;
  logic conf_q      = 1'b0;

  always @(negedge clk) begin
    if (a_conf) begin
      conf_total++;
      if (conf_q) conf_double++;
    end
    conf_q = a_conf;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, gap, base, dbl0, route_bad;

    prio_tbl[0] = '{3'b110, 2'd0};
    prio_tbl[1] = '{3'b101, 2'd1};
    prio_tbl[2] = '{3'b011, 2'd2};
    prio_tbl[3] = '{3'b000, 2'd0};
    prio_tbl[4] = '{3'b001, 2'd1};
    prio_tbl[5] = '{3'b100, 2'd0};

    route_tbl[0] = '{3'b010, 3'b000, 1'b0, 5'b10000};
    route_tbl[1] = '{3'b101, 3'b010, 1'b1, 5'b01010};
    route_tbl[2] = '{3'b111, 3'b101, 1'b1, 5'b10010};
    route_tbl[3] = '{3'b000, 3'b111, 1'b0, 5'b01000};

    a_sck = '0; a_ss_n = '1; a_mosi = '0; a_miso = 1'b0;
    b_sck = '0; b_ss_n = '1; b_mosi = '0; b_miso = 1'b0;

    // reset state
    #12;
    check("rst_out_ss_n",  32'(a_out_ss_n), 32'd1);
    check("rst_out_sck",   32'(a_out_sck),  32'd0);
    check("rst_owner",     32'(a_owner),    32'd0);
    check("rst_owner_vld", 32'(a_ov),       32'd0);
    check("rst_conflict",  32'(a_conf),     32'd0);
    check("rst_conf_cnt",  32'(a_cnt),      32'd0);
    check("rst_b_idle",    32'({b_out_ss_n, b_ov, b_src_miso}), 32'h200);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(2);

    // single source 1: grant exactly SYNC_STAGES+1 cycles after the fall
    a_ss_n[1] = 1'b0;
    cyc(2);
    check("grant_not_early", 32'(a_ov), 32'd0);
    cyc(1);
    check("grant_owner1", 32'({a_ov, a_owner}), 32'h5);
    check("own_ss_n_low", 32'(a_out_ss_n), 32'd0);
    a_sck[1] = 1'b1; #1;
    check("sck_follow_hi", 32'(a_out_sck), 32'd1);
    a_sck[1] = 1'b0; a_sck[0] = 1'b1; #1;
    check("sck_follow_lo", 32'(a_out_sck), 32'd0);

    for (int i = 0; i < 4; i++) begin
      a_sck = route_tbl[i].sck; a_mosi = route_tbl[i].mosi; a_miso = route_tbl[i].miso;
      #1;
      check($sformatf("route_vec%0d", i), 32'({a_out_sck, a_out_mosi, a_src_miso}), 32'(route_tbl[i].exp));
    end
    a_sck = '0; a_mosi = '0; a_miso = 1'b0;

    a_ss_n = 3'b111; #1;
    check("release_ss_n_hi", 32'(a_out_ss_n), 32'd1);
    cyc(3);
    check("release_ov_low", 32'(a_ov), 32'd0);
    check("owner_hold", 32'(a_owner), 32'd1);
    cyc(GUARD + 3);

    for (int i = 0; i < 6; i++) begin
      a_ss_n = prio_tbl[i].ss_n;
      cyc(3);
      check($sformatf("prio_vec%0d", i), 32'({a_ov, a_owner}), 32'({1'b1, prio_tbl[i].exp_owner}));
      a_ss_n = 3'b111;
      cyc(3 + GUARD + 2);
    end

    // sources 0 and 2 together; 2 waits out the guard gap
    a_ss_n = 3'b010;
    cyc(3);
    check("dual_owner0", 32'({a_ov, a_owner}), 32'h4);
    cyc(2);
    a_ss_n = 3'b011;
    rel = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (!a_ov) begin rel = k; break; end
    end
    check("dual_release_lat", 32'(rel), 32'd3);
    check("release_idle_ss", 32'(a_out_ss_n), 32'd1);
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (a_ov) break;
      gap++;
    end
    check("guard_gap", 32'(gap), 32'(GUARD));
    check("dual_owner2", 32'({a_ov, a_owner}), 32'h6);
    check("dual_conflict_none", 32'(a_cnt), 32'd0);
    a_ss_n = 3'b111;
    cyc(3 + GUARD + 2);

    // 300 conflicting falls from source 1 while source 0 owns the bus
    a_ss_n = 3'b110;
    cyc(3);
    check("conf_owner0", 32'({a_ov, a_owner}), 32'h4);
    base = conf_total; dbl0 = conf_double; route_bad = 0;
    a_sck = 3'b010;
    for (int i = 0; i < 300; i++) begin
      a_ss_n[1] = 1'b0;
      cyc(4);
      if (a_out_ss_n !== 1'b0 || a_out_sck !== 1'b0 || a_owner !== 2'd0 || a_ov !== 1'b1) route_bad++;
      a_ss_n[1] = 1'b1;
      cyc(4);
    end
    cyc(2);
    check("conf_pulses", 32'(conf_total - base), 32'd300);
    check("conf_one_cycle", 32'(conf_double - dbl0), 32'd0);
    check("conf_cnt_sat", 32'(a_cnt), 32'd255);
    check("conf_route_kept", 32'(route_bad), 32'd0);

    // asynchronous reset mid-byte
    a_sck = 3'b001; a_miso = 1'b1; #1;
    check("pre_rst_sck", 32'(a_out_sck), 32'd1);
    rst = 1'b1; #1;
    check("async_rst_ss_n", 32'(a_out_ss_n), 32'd1);
    check("async_rst_sck",  32'(a_out_sck),  32'd0);
    check("async_rst_cnt",  32'(a_cnt),      32'd0);
    check("async_rst_miso", 32'({a_ov, a_src_miso}), 32'd0);
    cyc(2);
    rst = 1'b0;
    rel = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (a_ov) begin rel = k; break; end
    end
    check("regrant_after_rst", 32'(rel), 32'd3);
    check("regrant_owner", 32'(a_owner), 32'd0);
    a_ss_n = 3'b111; a_sck = '0; a_miso = 1'b0;
    cyc(3 + GUARD + 2);

    // eight sources, one-cycle guard
    b_ss_n = 8'h7F;
    cyc(3);
    check("b_owner7", 32'({b_ov, b_owner}), 32'hF);
    b_miso = 1'b1; #1;
    check("b_miso_hi", 32'(b_src_miso), 32'h80);
    b_miso = 1'b0; #1;
    check("b_miso_lo", 32'(b_src_miso), 32'h00);
    b_ss_n = 8'h77;
    cyc(4);
    b_ss_n = 8'hF7;
    rel = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (!b_ov) begin rel = k; break; end
    end
    check("b_release_lat", 32'(rel), 32'd3);
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (b_ov) break;
      gap++;
    end
    check("b_guard_gap", 32'(gap), 32'd1);
    check("b_owner3", 32'(b_owner), 32'd3);
    check("b_conflict_cnt", 32'(b_cnt), 32'd1);
    b_ss_n = 8'hFF;
    cyc(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_src_arbiter.md
SPI_SRC_ARBITER -- requirements
Module: spi_src_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 3, giving the number of SPI master sources (range 2..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the slave-select synchroniser depth (range 2..4).
REQ-003 SHALL have parameter GUARD_CYCLES, default 4, giving the idle gap enforced after release (range 1..255).
REQ-004 SHALL have parameter SCK_IDLE, default 1'b0, giving the out_sck level when no source owns the bus.
REQ-005 SHALL have port CLOCK_50  in  1  system clock; one clock, all state on its rising edge.
REQ-006 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port src_sck  in  NSRC  per-source SPI clock; asynchronous to CLOCK_50.
REQ-008 SHALL have port src_ss_n  in  NSRC  per-source active-low slave select.
REQ-009 SHALL have port src_mosi  in  NSRC  per-source master data out.
REQ-010 SHALL have port miso_in  in  1  shared slave data returned from the guest core.
REQ-011 SHALL have port src_miso  out  NSRC  per-source data in; only the owner bit carries miso_in, all others 0.
REQ-012 SHALL have port out_sck, out_mosi, out_ss_n  out  1 each  bus routed to the guest core.
REQ-013 SHALL have port owner  out  OW=max(1,$clog2(NSRC))  index of the current owner.
REQ-014 SHALL have port owner_valid  out  1  high while a source owns the bus.
REQ-015 SHALL have port conflict  out  1  one-cycle pulse when a non-owner select falls while the bus is owned.
REQ-016 SHALL have port conflict_cnt  out  8  saturating count of conflict pulses.

Function
REQ-017 SHALL pass each src_ss_n bit through a SYNC_STAGES flop chain that resets to 1; the arbiter SHALL use only the synchronised copies.
REQ-018 SHALL implement FSM states IDLE, OWN, RELEASE.
REQ-019 In IDLE, when any synchronised select is low, SHALL latch the lowest such index into owner, set owner_valid, and enter OWN on the next edge.
REQ-020 In OWN, SHALL route out_sck/out_mosi/out_ss_n from src_*[owner] and miso_in to src_miso[owner], using combinational routing from the registered owner only.
REQ-021 In OWN, when the owner's synchronised select goes high, SHALL clear owner_valid, load the guard counter with GUARD_CYCLES and enter RELEASE.
REQ-022 In RELEASE, SHALL decrement the counter each cycle and enter IDLE when it reaches 0; no grant SHALL occur in RELEASE, even if a select is already low.
REQ-023 In IDLE and RELEASE, out_ss_n SHALL be 1, out_sck SHALL be SCK_IDLE, out_mosi 0 and src_miso all 0.
REQ-024 Grant latency SHALL be SYNC_STAGES+1 CLOCK_50 cycles from the select falling edge; masters SHALL hold select low at least SYNC_STAGES+2 cycles before the first SCK edge.
REQ-025 SHALL raise conflict for one cycle on the falling edge of a synchronised non-owner select while in OWN.
REQ-026 conflict_cnt SHALL increment on each conflict and saturate at 255.
REQ-027 On simultaneous requests, the lowest index SHALL win; losers stay pending and are granted by priority after RELEASE.
REQ-028 owner SHALL hold its last value outside OWN.

Reset
REQ-029 While RESET is high, state SHALL be IDLE, owner 0, owner_valid 0, conflict 0, conflict_cnt 0, guard counter 0, synchronisers 1, and routed outputs SHALL be at idle levels.
REQ-030 RESET asserted mid-transfer SHALL force idle outputs immediately, without waiting for a clock edge; after release, arbitration SHALL restart from IDLE.

Structure
REQ-031 Package neptuno_spi_pkg SHALL hold the FSM state enum and the OW width function.
REQ-032 The synchroniser SHALL be a sub-module sync_bit, parameterised by SYNC_STAGES with reset value 1, instantiated NSRC times.

Verification
REQ-033 Scenario: source 1 ss_n falls, defaults -> owner=1, owner_valid=1 exactly 3 cycles later, and out_sck follows src_sck[1].
REQ-034 Scenario: sources 0 and 2 fall in the same cycle -> owner=0; after 0 releases, owner_valid is low for 4 cycles, then owner=2.
REQ-035 Scenario: during owner 0, source 1 falls 300 times -> conflict pulses 300 times and conflict_cnt=255; routing is unchanged.
REQ-036 Scenario: RESET pulsed mid-byte -> out_ss_n=1 and out_sck=SCK_IDLE in the same cycle, with conflict_cnt=0.
REQ-037 Scenario: NSRC=8, GUARD_CYCLES=1, source 7 alone -> owner=7, src_miso[7]=miso_in and all other src_miso bits 0.
